// File: rtl/mmio_pkg.sv
// Register map shared by the MMIO responder and its bench: word offsets,
// STATUS bit layout and the helper that assembles the STATUS word.
package mmio_pkg;

  typedef enum logic [1:0] {
    OFF_TXDATA  = 2'd0,
    OFF_STATUS  = 2'd1,
    OFF_CYCLES  = 2'd2,
    OFF_SCRATCH = 2'd3
  } mmio_offset_e;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 4;

  // count arrives zero-extended to 8 bits; depths up to 128 fit
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       overflow,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                      = '0;
    s[ST_EMPTY]            = empty;
    s[ST_FULL]             = full;
    s[ST_OVERFLOW]         = overflow;
    s[ST_COUNT_LSB +: 8]   = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push is accepted when full only if a pop happens in the
// same cycle, so occupancy never exceeds DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped peripheral: TX byte FIFO, STATUS, free-running CYCLES counter
// and a SCRATCH register, with registered (1-cycle) read data.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [11:0] MMIO_BASE  = 12'hF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [11:0]  offset;
  logic         mapped;
  mmio_offset_e sel;
  logic         wr_tx;
  logic         wr_status;
  logic         wr_cycles;
  logic         wr_scratch;
  logic         fifo_empty;
  logic         fifo_full;
  logic [CW-1:0] fifo_count;
  logic         pop;
  logic         overflow_event;
  logic         overflow;
  logic [31:0]  cycles;
  logic [31:0]  scratch;
  logic [31:0]  rdata;

  assign offset = address - MMIO_BASE;
  assign mapped = (address >= MMIO_BASE) && (offset < 12'd4);
  assign sel    = mmio_offset_e'(offset[1:0]);

  assign wr_tx      = wren && mapped && (sel == OFF_TXDATA);
  assign wr_status  = wren && mapped && (sel == OFF_STATUS);
  assign wr_cycles  = wren && mapped && (sel == OFF_CYCLES);
  assign wr_scratch = wren && mapped && (sel == OFF_SCRATCH);

  assign pop            = !fifo_empty && out_ready;
  assign overflow_event = wr_tx && fifo_full && !pop;
  assign out_valid      = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .din   (data[7:0]),
    .dout  (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Overflow is sticky; a same-cycle overflow beats a software clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      cycles   <= '0;
      scratch  <= '0;
    end else begin
      if (overflow_event)                       overflow <= 1'b1;
      else if (wr_status && data[ST_OVERFLOW])  overflow <= 1'b0;
      cycles <= wr_cycles ? data : cycles + 32'd1;
      if (wr_scratch) scratch <= data;
    end
  end

  always_comb begin
    rdata = '0;
    if (mapped) begin
      case (sel)
        OFF_TXDATA:  rdata = '0;
        OFF_STATUS:  rdata = pack_status(fifo_empty, fifo_full, overflow, 8'(fifo_count));
        OFF_CYCLES:  rdata = cycles;
        OFF_SCRATCH: rdata = scratch;
        default:     rdata = '0;
      endcase
    end
  end

  // Registering pre-edge state gives read-before-write on the same offset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= rdata;
  end

endmodule
